// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential divider: width, FSM encoding and
// the single-bit full-adder cell the subtractor is built from.
package div16_seq_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell, returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

endpackage

// File: rtl/div16_seq_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface div16_seq_if
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div16_seq_sub_borrow.sv
// Ripple subtractor: x - y computed as x + ~y + 1 through a chain of
// full-adder cells. borrow is the inverted final carry.
module div16_seq_sub_borrow
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH + 1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic       carry;
    logic [1:0] fa;

    // Walk the carry from LSB to MSB, one full-adder cell per bit
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        fa    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fa      = full_add(x[i], ~y[i], carry);
            diff[i] = fa[0];
            carry   = fa[1];
        end
    end

    assign borrow = ~carry;

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
// Divide by zero takes a single pass through RUN with no iterations so that
// done still arrives one cycle later than a plain IDLE->DONE hop would give.
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic        clk,
    input logic        rst_n,
    div16_seq_if.slave bus
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic             zero_pend;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] iter_cnt;

    // Partial remainder and trial values carry one extra bit: shifting a
    // remainder >= 2^(WIDTH-1) left would otherwise lose its top bit.
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff_full;
    logic [WIDTH:0]   next_partial;
    logic             borrow;

    assign trial = (partial << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};

    div16_seq_sub_borrow #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .x      (trial),
        .y      ({1'b0, divisor}),
        .diff   (diff_full),
        .borrow (borrow)
    );

    assign next_partial = borrow ? trial : diff_full;
    assign q_next       = (q_shift << 1) | {{(WIDTH-1){1'b0}}, ~borrow};

    // FSM, iteration datapath and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            zero_pend   <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dividend    <= '0;
            divisor     <= '0;
            q_shift     <= '0;
            partial     <= '0;
            iter_cnt    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividend  <= bus.a;
                        divisor   <= bus.b;
                        zero_pend <= (bus.b == '0);
                        dbz_r     <= 1'b0;
                        partial   <= '0;
                        q_shift   <= '0;
                        iter_cnt  <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (zero_pend) begin
                        quotient_r  <= '1;
                        remainder_r <= dividend;
                        dbz_r       <= 1'b1;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        partial  <= next_partial;
                        dividend <= dividend << 1;
                        q_shift  <= q_next;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                        if (iter_cnt == LAST_ITER) begin
                            quotient_r  <= q_next;
                            remainder_r <= next_partial[WIDTH-1:0];
                            done_r      <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div16_seq.sv
// Directed bench for div16_seq with a result scoreboard.
module tb_div16_seq;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    div16_seq_if #(.WIDTH(16)) bus ();

    div16_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse and record the expected result
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        if (y == 16'd0) begin
            e.q = 16'hFFFF; e.r = x; e.z = 1'b1;
        end else begin
            e.q = x / y; e.r = x % y; e.z = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, check latency and the scoreboard entry
    task automatic checkOutput(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (lat < 0) return;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_quotient"}, bus.quotient, e.q);
        check({tag, "_remainder"}, bus.remainder, e.r);
        check({tag, "_dbz"}, bus.div_by_zero, e.z);
        check({tag, "_busy"}, bus.busy, 1'b1);
    endtask

    initial begin
        int          dones;
        int          idx;
        int          last_done;
        int          low_cycles;
        logic        prev_busy;
        exp_t        e;
        logic [15:0] op_a [3];
        logic [15:0] op_b [3];

        checks   = 0;
        failures = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_quotient", bus.quotient, 16'h0);
        check("rst_remainder", bus.remainder, 16'h0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic division and width boundaries
        applyStimulus(16'd100, 16'd7);
        checkOutput("d100_7", 16);
        applyStimulus(16'hFFFF, 16'h8000);
        checkOutput("dffff_8000", 16);
        applyStimulus(16'hFFFF, 16'h0001);
        checkOutput("dffff_1", 16);

        // Divide by zero, then a normal op clears the flag
        applyStimulus(16'd5, 16'd0);
        checkOutput("d5_0", 1);
        @(negedge clk);
        check("d5_0_pulse", bus.done, 1'b0);
        check("d5_0_idle", bus.busy, 1'b0);
        check("d5_0_held_q", bus.quotient, 16'hFFFF);
        applyStimulus(16'd9, 16'd3);
        check("d9_3_dbz_cleared", bus.div_by_zero, 1'b0);
        check("d9_3_q_not_early", bus.quotient, 16'hFFFF);
        checkOutput("d9_3", 16);

        // Start during RUN is ignored, exactly one done
        applyStimulus(16'd1000, 16'd10);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd7;
        bus.b     = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("d1000_10", 12);
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("d1000_10_single_done", dones, 0);

        // Reset in the middle of an operation
        applyStimulus(16'd50000, 16'd3);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_quotient", bus.quotient, 16'h0);
        check("midrst_remainder", bus.remainder, 16'h0);
        check("midrst_dbz", bus.div_by_zero, 1'b0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", dones, 0);
        applyStimulus(16'd3, 16'd5);
        checkOutput("d3_5", 16);

        // start held high across three back-to-back operations
        op_a[0] = 16'd12; op_b[0] = 16'd4;
        op_a[1] = 16'd13; op_b[1] = 16'd4;
        op_a[2] = 16'd0;  op_b[2] = 16'd9;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = op_a[0];
        bus.b     = op_b[0];
        e.q = op_a[0] / op_b[0]; e.r = op_a[0] % op_b[0]; e.z = 1'b0;
        sb.push_back(e);
        idx        = 1;
        prev_busy  = 1'b0;
        dones      = 0;
        last_done  = -1;
        low_cycles = 0;
        for (int n = 0; n < 80 && dones < 3; n++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                if (idx < 3) begin
                    bus.a = op_a[idx];
                    bus.b = op_b[idx];
                    e.q = op_a[idx] / op_b[idx]; e.r = op_a[idx] % op_b[idx]; e.z = 1'b0;
                    sb.push_back(e);
                    idx++;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (!bus.busy) low_cycles++;
            if (bus.done) begin
                dones++;
                if (last_done >= 0) begin
                    check("b2b_spacing", n - last_done, 18);
                    check("b2b_busy_low", low_cycles, 1);
                end
                last_done  = n;
                low_cycles = 0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_quotient", bus.quotient, e.q);
                    check("b2b_remainder", bus.remainder, e.r);
                end else begin
                    check("b2b_sb_empty", 32'd0, 32'd1);
                end
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        check("b2b_done_count", dones, 3);
        check("sb_drained", sb.size(), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
